// File: rtl/switch_box_config_loader_pkg.sv
// Shared definitions for the switch box configuration loader.
//   SBE_CFG_W  : width of one switch_box_element control bus (c)
//   state_t    : loader FSM states
//   num_words  : data words needed to carry one full configuration image
package sb_cfg_pkg;

  localparam int unsigned SBE_CFG_W = 12;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_CHECK,
    ST_DONE,
    ST_ERROR
  } state_t;

  function automatic int unsigned num_words(input int unsigned num_elems,
                                            input int unsigned word_w);
    return (num_elems * SBE_CFG_W + word_w - 1) / word_w;
  endfunction

endpackage

// File: rtl/switch_box_config_loader_if.sv
// Word-serial configuration bitstream channel.
//   cfg_start : one-cycle pulse, begins or restarts an image load
//   cfg_valid : cfg_data holds a word this cycle
//   cfg_data  : bitstream word
//   cfg_ready : loader accepts a word this cycle
// master = bitstream source, slave = loader.
interface switch_box_config_loader_if #(
  parameter int unsigned WORD_W = 8
);
  logic              cfg_start;
  logic              cfg_valid;
  logic [WORD_W-1:0] cfg_data;
  logic              cfg_ready;

  modport master (output cfg_start, output cfg_valid, output cfg_data, input cfg_ready);
  modport slave  (input cfg_start, input cfg_valid, input cfg_data, output cfg_ready);
endinterface

// File: rtl/switch_box_config_loader_shadow.sv
// Shadow register that assembles an image word by word before commit.
//   clk, rst : clock, asynchronous active-high reset
//   clr      : clear the whole shadow image
//   we       : write wdata into word slot idx
//   idx      : word index, word k lands at bits [k*WORD_W +: WORD_W]
//   wdata    : bitstream word; bits beyond TOTAL_BITS are dropped
//   shadow   : assembled image
module sb_cfg_shadow #(
  parameter int unsigned TOTAL_BITS = 48,
  parameter int unsigned WORD_W     = 8,
  parameter int unsigned CNT_W      = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  we,
  input  logic [CNT_W-1:0]      idx,
  input  logic [WORD_W-1:0]     wdata,
  output logic [TOTAL_BITS-1:0] shadow
);

  localparam int unsigned IW = (WORD_W > 1) ? $clog2(WORD_W) : 1;

  // Per-bit write select: bit i belongs to word i/WORD_W. Iterating over
  // TOTAL_BITS only means padding bits of the last word never get a home.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow <= '0;
    end else if (clr) begin
      shadow <= '0;
    end else if (we) begin
      for (int unsigned i = 0; i < TOTAL_BITS; i++) begin
        if (idx == CNT_W'(i / WORD_W)) shadow[i] <= wdata[IW'(i % WORD_W)];
      end
    end
  end

endmodule

// File: rtl/switch_box_config_loader.sv
// Configuration writer for a column of switch_box_element instances.
// Collects NUM_WORDS bitstream words into a shadow image, then compares the
// next word with the XOR of all data words; only on a match is the image
// committed to cfg_out, so elements never see a partial configuration.
//   clk, rst  : clock, asynchronous active-high reset
//   cfg       : bitstream channel (slave side)
//   cfg_out   : committed control, element e uses cfg_out[12*e+11:12*e]
//   cfg_busy  : load or checksum check in progress
//   cfg_done  : committed image valid since last successful load
//   cfg_err   : last load failed its checksum
module switch_box_config_loader
  import sb_cfg_pkg::*;
#(
  parameter int unsigned NUM_ELEMS = 4,
  parameter int unsigned WORD_W    = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  switch_box_config_loader_if.slave        cfg,
  output logic [NUM_ELEMS*SBE_CFG_W-1:0]   cfg_out,
  output logic                             cfg_busy,
  output logic                             cfg_done,
  output logic                             cfg_err
);

  localparam int unsigned TOTAL_BITS = NUM_ELEMS * SBE_CFG_W;
  localparam int unsigned NUM_WORDS  = num_words(NUM_ELEMS, WORD_W);
  localparam int unsigned CNT_W      = $clog2(NUM_WORDS + 1);

  state_t                  state, state_n;
  logic [CNT_W-1:0]        cnt;
  logic [WORD_W-1:0]       csum;
  logic [TOTAL_BITS-1:0]   shadow;
  logic                    accept;
  logic                    clr;
  logic                    we;
  logic                    commit;

  // Ready depends on state only, never on cfg_valid.
  assign cfg.cfg_ready = (state == ST_LOAD) || (state == ST_CHECK);
  assign accept        = cfg.cfg_valid && cfg.cfg_ready;

  assign cfg_busy = (state == ST_LOAD) || (state == ST_CHECK);
  assign cfg_done = (state == ST_DONE);
  assign cfg_err  = (state == ST_ERROR);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_n;
  end

  // cfg_start outranks any handshake in the same cycle; that word is dropped.
  always_comb begin
    state_n = state;
    clr     = 1'b0;
    we      = 1'b0;
    commit  = 1'b0;
    if (cfg.cfg_start) begin
      state_n = ST_LOAD;
      clr     = 1'b1;
    end else begin
      case (state)
        ST_LOAD: begin
          if (accept) begin
            we = 1'b1;
            if (cnt == CNT_W'(NUM_WORDS - 1)) state_n = ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (accept) begin
            if (cfg.cfg_data == csum) begin
              state_n = ST_DONE;
              commit  = 1'b1;
            end else begin
              state_n = ST_ERROR;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Checksum covers the full word, padding bits included.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      csum <= '0;
    end else if (clr) begin
      cnt  <= '0;
      csum <= '0;
    end else if (we) begin
      cnt  <= cnt + 1'b1;
      csum <= csum ^ cfg.cfg_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         cfg_out <= '0;
    else if (commit) cfg_out <= shadow;
  end

  sb_cfg_shadow #(
    .TOTAL_BITS (TOTAL_BITS),
    .WORD_W     (WORD_W),
    .CNT_W      (CNT_W)
  ) u_shadow (
    .clk    (clk),
    .rst    (rst),
    .clr    (clr),
    .we     (we),
    .idx    (cnt),
    .wdata  (cfg.cfg_data),
    .shadow (shadow)
  );

endmodule

// File: tb/tb_switch_box_config_loader.sv
// Scoreboard bench for switch_box_config_loader: a 4-element instance for the
// main scenarios and a 3-element instance for last-word padding truncation.
module tb_switch_box_config_loader;
  import sb_cfg_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  switch_box_config_loader_if #(.WORD_W(8)) if1 ();
  switch_box_config_loader_if #(.WORD_W(8)) if2 ();

  logic [47:0] out1;
  logic        busy1, done1, err1;
  logic [35:0] out2;
  logic        busy2, done2, err2;

  switch_box_config_loader #(.NUM_ELEMS(4), .WORD_W(8)) dut1 (
    .clk(clk), .rst(rst), .cfg(if1),
    .cfg_out(out1), .cfg_busy(busy1), .cfg_done(done1), .cfg_err(err1)
  );

  switch_box_config_loader #(.NUM_ELEMS(3), .WORD_W(8)) dut2 (
    .clk(clk), .rst(rst), .cfg(if2),
    .cfg_out(out2), .cfg_busy(busy2), .cfg_done(done2), .cfg_err(err2)
  );

  typedef struct {
    string       name;
    logic [47:0] out;
    logic        done;
    logic        err;
  } exp_t;

  exp_t        q1[$];
  exp_t        q2[$];
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  int unsigned rdy_cnt;

  localparam logic [47:0] IMG_A = 48'h2010_0804_0201;
  localparam logic [47:0] IMG_B = 48'h6655_4433_2211;

  logic [7:0] seq_a[7]   = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h3F};
  logic [7:0] seq_bad[7] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h3E};
  logic [7:0] seq_b[7]   = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77};
  logic [7:0] seq_n3[6]  = '{8'h00, 8'h00, 8'h00, 8'h00, 8'hFF, 8'hFF};

  function automatic void check(input string name, input logic [47:0] act,
                                input logic [47:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endfunction

  // Monitors: a completion (rising done or err) pops the next expected image.
  logic fin1_q = 1'b0;
  logic fin2_q = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    if ((done1 | err1) && !fin1_q) begin
      if (q1.size() == 0) begin
        check("dut1_unexpected_completion", {46'b0, done1, err1}, 48'h0);
      end else begin
        e = q1.pop_front();
        check({e.name, "_out"},  out1, e.out);
        check({e.name, "_done"}, {47'b0, done1}, {47'b0, e.done});
        check({e.name, "_err"},  {47'b0, err1},  {47'b0, e.err});
        check({e.name, "_busy"}, {47'b0, busy1}, 48'h0);
      end
    end
    fin1_q <= done1 | err1;
  end

  always @(negedge clk) begin
    exp_t e;
    if ((done2 | err2) && !fin2_q) begin
      if (q2.size() == 0) begin
        check("dut2_unexpected_completion", {46'b0, done2, err2}, 48'h0);
      end else begin
        e = q2.pop_front();
        check({e.name, "_out"},  {12'b0, out2}, e.out);
        check({e.name, "_done"}, {47'b0, done2}, {47'b0, e.done});
        check({e.name, "_err"},  {47'b0, err2},  {47'b0, e.err});
      end
    end
    fin2_q <= done2 | err2;
  end

  // All drive tasks start and end #1 after a rising edge.
  task automatic idle1();
    if1.cfg_start = 1'b0;
    if1.cfg_valid = 1'b0;
    if1.cfg_data  = 8'h00;
  endtask

  task automatic start1();
    if1.cfg_start = 1'b1;
    if1.cfg_valid = 1'b0;
    @(posedge clk); #1;
    if1.cfg_start = 1'b0;
  endtask

  task automatic send1(input logic [7:0] d, input bit gaps);
    int unsigned budget = 0;
    bit ok = 1'b0;
    if (gaps && $urandom_range(0, 1) == 1) begin
      if1.cfg_valid = 1'b0;
      if1.cfg_data  = 8'($urandom);
      @(posedge clk); #1;
    end
    if1.cfg_valid = 1'b1;
    if1.cfg_data  = d;
    while (!ok && budget < 50) begin
      ok = if1.cfg_ready;
      if (ok) rdy_cnt++;
      @(posedge clk); #1;
      budget++;
    end
    if (!ok) check("dut1_handshake_timeout", 48'h0, 48'h1);
  endtask

  task automatic load1(input logic [7:0] w[7], input bit gaps);
    for (int i = 0; i < 7; i++) send1(w[i], gaps);
    idle1();
  endtask

  task automatic send2(input logic [7:0] d);
    int unsigned budget = 0;
    bit ok = 1'b0;
    if2.cfg_valid = 1'b1;
    if2.cfg_data  = d;
    while (!ok && budget < 50) begin
      ok = if2.cfg_ready;
      @(posedge clk); #1;
      budget++;
    end
    if (!ok) check("dut2_handshake_timeout", 48'h0, 48'h1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    idle1();
    if2.cfg_start = 1'b0;
    if2.cfg_valid = 1'b0;
    if2.cfg_data  = 8'h00;
    #12;
    check("reset_out",   out1, 48'h0);
    check("reset_flags", {44'b0, busy1, done1, err1, if1.cfg_ready}, 48'h0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Bad checksum: error, nothing committed; a new start clears the error.
    q1.push_back('{"bad_csum", 48'h0, 1'b0, 1'b1});
    start1();
    load1(seq_bad, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    start1();
    check("err_cleared_by_start", {45'b0, err1, done1, busy1}, 48'h1);

    // Clean load A (restarting the open load), ready counted per word.
    q1.push_back('{"load_a", IMG_A, 1'b1, 1'b0});
    rdy_cnt = 0;
    start1();
    load1(seq_a, 1'b0);
    check("load_a_ready_cycles", 48'(rdy_cnt), 48'd7);
    check("load_a_direct", out1, IMG_A);
    check("load_a_after_flags", {45'b0, busy1, done1, if1.cfg_ready}, 48'h2);
    repeat (2) @(posedge clk);
    #1;

    // Load B: after 3 words old image still drives, done is low.
    q1.push_back('{"load_b", IMG_B, 1'b1, 1'b0});
    start1();
    for (int i = 0; i < 3; i++) send1(seq_b[i], 1'b0);
    idle1();
    check("load_b_partial_out",  out1, IMG_A);
    check("load_b_partial_flags", {46'b0, done1, busy1}, 48'h1);
    for (int i = 3; i < 7; i++) send1(seq_b[i], 1'b0);
    idle1();
    repeat (2) @(posedge clk);
    #1;

    // Restart after 3 words, start coinciding with a valid word.
    q1.push_back('{"restart", IMG_A, 1'b1, 1'b0});
    start1();
    for (int i = 0; i < 3; i++) send1(seq_a[i], 1'b0);
    if1.cfg_start = 1'b1;
    if1.cfg_valid = 1'b1;
    if1.cfg_data  = 8'hA5;
    @(posedge clk); #1;
    if1.cfg_start = 1'b0;
    load1(seq_a, 1'b0);
    repeat (2) @(posedge clk);
    #1;

    q1.push_back('{"load_b2", IMG_B, 1'b1, 1'b0});
    start1();
    load1(seq_b, 1'b0);
    repeat (2) @(posedge clk);
    #1;

    // Valid while not ready must be ignored.
    if1.cfg_valid = 1'b1;
    if1.cfg_data  = 8'hC3;
    for (int i = 0; i < 3; i++) begin
      check("idle_valid_ready", {47'b0, if1.cfg_ready}, 48'h0);
      @(posedge clk); #1;
    end
    idle1();
    check("idle_valid_out",  out1, IMG_B);
    check("idle_valid_done", {47'b0, done1}, 48'h1);

    // Load A with random valid gaps.
    q1.push_back('{"gaps", IMG_A, 1'b1, 1'b0});
    start1();
    load1(seq_a, 1'b1);
    repeat (2) @(posedge clk);
    #1;

    // Asynchronous reset mid-load.
    start1();
    for (int i = 0; i < 3; i++) send1(seq_b[i], 1'b0);
    idle1();
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("midreset_out",   out1, 48'h0);
    check("midreset_flags", {44'b0, busy1, done1, err1, if1.cfg_ready}, 48'h0);
    #2 rst = 1'b0;
    @(posedge clk); #1;

    // 3-element instance: padding bits of the last word are dropped.
    q2.push_back('{"ne3", 48'h0000_000F_0000_0000 >> 0, 1'b1, 1'b0});
    if2.cfg_start = 1'b1;
    @(posedge clk); #1;
    if2.cfg_start = 1'b0;
    for (int i = 0; i < 6; i++) send2(seq_n3[i]);
    if2.cfg_valid = 1'b0;
    check("ne3_direct", {12'b0, out2}, 48'h0000_000F_0000_0000);
    repeat (3) @(posedge clk);
    #1;

    check("q1_pending", 48'(q1.size()), 48'h0);
    check("q2_pending", 48'(q2.size()), 48'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
